multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the single-memory-port RISC-V datapath over FETCH/DECODE/EXEC/MEM/WB.
- Supported opcodes are the same set as the combinational decoder; per-state strobes are driven directly to the PC, IR, register file, ALU and data memory.
- Waits on instruction/data memory ready handshakes with a bounded timeout.
- Enters a sticky TRAP on an illegal opcode or a bus timeout.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in FETCH or MEM waiting for ready before TRAP; 0 disables the timeout; legal range 0..255.

Ports:
- clk_i  input  1  system clock; all state changes on rising edge
- rst_ni  input  1  reset; synchronous, active-low
- opcode_i  input  7  opcode field of the instruction register
- zero_i  input  1  ALU zero flag (branch compare result)
- imem_ready_i  input  1  instruction memory data valid
- dmem_ready_i  input  1  data memory access complete
- imem_req_o  output  1  instruction fetch request
- ir_we_o  output  1  instruction register write enable
- pc_we_o  output  1  PC write enable
- branch_o  output  1  PC source select = branch/jump target
- regwrite_o  output  1  register file write enable
- alusrc_o  output  1  ALU operand B: 1 = immediate, 0 = register
- memtoreg_o  output  1  writeback source: 1 = memory data
- memread_o  output  1  data memory read strobe
- memwrite_o  output  1  data memory write strobe
- ALUOp_o  output  3  000 add, 001 compare/sub, 010 R-funct, 011 I-funct
- trap_o  output  1  sticky trap flag
- trap_cause_o  output  2  00 none, 01 illegal opcode, 10 bus timeout
- state_o  output  3  current state encoding

Behaviour:
- Reset: rst_ni sampled low at a rising edge -> state START, op_q=0, wait_cnt=0, trap_cause_o=00. Every output is 0 in START except state_o=000. Applies mid-operation, including MEM with a strobe active; the strobe drops after that edge.
- State encoding: START 000, FETCH 001, DECODE 010, EXEC 011, MEM 100, WB 101, TRAP 110. Outputs are Moore, decoded from state_q and op_q.
- START: all outputs 0; always -> FETCH.
- FETCH: imem_req_o=1.
  - imem_ready_i=1 (allowed in the same cycle as the request): ir_we_o=1, pc_we_o=1 (PC+4), branch_o=0; -> DECODE.
- DECODE: no strobes. op_q <= opcode_i at exit.
  - Opcode in {0010011, 0110011, 0100011, 0000011, 1100011, 1100111}: -> EXEC.
  - Any other opcode: -> TRAP, cause 01.
- EXEC:
  - R: ALUOp=010, alusrc=0; -> WB.
  - I: ALUOp=011, alusrc=1; -> WB.
  - L/S: ALUOp=000, alusrc=1; -> MEM.
  - B: ALUOp=001, alusrc=0, branch_o=1, pc_we_o=zero_i; -> FETCH.
  - J (1100111): ALUOp=000, branch_o=1, pc_we_o=1; -> FETCH.
- MEM: alusrc=1, ALUOp=000 held stable. memread_o=1 (L) or memwrite_o=1 (S), held until dmem_ready_i=1.
  - Then L -> WB; S -> FETCH.
- WB: regwrite_o=1; memtoreg_o=1 for L, 0 for R/I; -> FETCH.
- TRAP: trap_o=1, trap_cause_o held, all strobes 0. Leaves only on reset.
- Timeout:
  - wait_cnt clears on entry to FETCH/MEM and increments each cycle ready is low.
  - TRAP (cause 10) when ready is low and wait_cnt == TIMEOUT_CYCLES-1, i.e. ready must arrive within TIMEOUT_CYCLES cycles of entry.
  - Ready in the expiry cycle wins: no trap.
  - wait_cnt is 8 bits and saturates when TIMEOUT_CYCLES=0.
- Latency with zero-wait memories:
  - B/J: 3 cycles.
  - R/I/S: 4 cycles.
  - L: 5 cycles.
  - Each wait cycle adds 1.
- Never asserted together: memread_o with memwrite_o; regwrite_o outside WB; ir_we_o outside FETCH.

Optional Feature:
- MCTRL_PERF_CNT_EN defined:
  - Adds output instret_o [31:0].
  - Increments on every transition into FETCH from EXEC, MEM or WB (one retired instruction).
  - Wraps 0xFFFFFFFF -> 0; cleared by reset; frozen in TRAP.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then R-type 0110011, both readies tied 1 -> state_o sequence 000,001,010,011,101,001; regwrite_o=1 only in WB; ALUOp_o=010 in EXEC.
- Load 0000011 with dmem_ready_i low 3 cycles -> memread_o=1 for 4 consecutive cycles, then WB with memtoreg_o=1 and regwrite_o=1; total 8 cycles FETCH->FETCH.
- Branch 1100011 with zero_i=1, then zero_i=0 -> pc_we_o=1 / 0 in EXEC; branch_o=1 in both cases; ALUOp_o=001.
- Opcode 1111111 -> TRAP after DECODE; trap_o=1, trap_cause_o=01; no strobes for 20 cycles; rst_ni low one edge -> START, trap_o=0.
- TIMEOUT_CYCLES=4, imem_ready_i held 0 -> TRAP on 4th FETCH cycle, cause 10. Ready asserted on the 4th cycle instead -> DECODE, no trap.
- With MCTRL_PERF_CNT_EN, run 3 instructions (I, S, B) -> instret_o=3; preload the counter to 0xFFFFFFFF via force, one retire -> 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM sequencing FETCH/DECODE/EXEC/MEM/WB with bounded memory waits and a sticky trap.
// Optional retired-instruction counter (instret_o) enabled by defining MCTRL_PERF_CNT_EN.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [6:0] opcode_i,
   input  logic       zero_i,
   input  logic       imem_ready_i,
   input  logic       dmem_ready_i,
   output logic       imem_req_o,
   output logic       ir_we_o,
   output logic       pc_we_o,
   output logic       branch_o,
   output logic       regwrite_o,
   output logic       alusrc_o,
   output logic       memtoreg_o,
   output logic       memread_o,
   output logic       memwrite_o,
   output logic [2:0] ALUOp_o,
   output logic       trap_o,
   output logic [1:0] trap_cause_o,
   output logic [2:0] state_o
`ifdef MCTRL_PERF_CNT_EN
   ,
   output logic [31:0] instret_o
`endif
);

   // Handshake: FETCH/MEM hold their request strobe until the matching ready is
   // seen high at a rising edge; ready in the same cycle as the request is accepted.
   typedef enum logic [2:0] {
      S_START  = 3'b000,
      S_FETCH  = 3'b001,
      S_DECODE = 3'b010,
      S_EXEC   = 3'b011,
      S_MEM    = 3'b100,
      S_WB     = 3'b101,
      S_TRAP   = 3'b110
   } state_t;

   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_B = 7'b1100011;
   localparam logic [6:0] OP_J = 7'b1100111;

   localparam bit         TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

   state_t     state_q, state_d;
   logic [6:0] op_q, op_d;
   logic [7:0] wait_q, wait_d;
   logic [1:0] cause_q, cause_d;
   logic       expired;
   logic [7:0] wait_inc;

   function automatic logic is_legal(input logic [6:0] op);
      return (op == OP_I) || (op == OP_R) || (op == OP_S) ||
             (op == OP_L) || (op == OP_B) || (op == OP_J);
   endfunction

   assign expired  = TO_EN && (wait_q == TO_LAST);
   assign wait_inc = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      wait_d     = 8'd0;
      cause_d    = cause_q;
      imem_req_o = 1'b0;
      ir_we_o    = 1'b0;
      pc_we_o    = 1'b0;
      branch_o   = 1'b0;
      regwrite_o = 1'b0;
      alusrc_o   = 1'b0;
      memtoreg_o = 1'b0;
      memread_o  = 1'b0;
      memwrite_o = 1'b0;
      ALUOp_o    = 3'b000;
      trap_o     = 1'b0;
      case (state_q)
         S_START: state_d = S_FETCH;
         S_FETCH: begin
            imem_req_o = 1'b1;
            if (imem_ready_i) begin
               ir_we_o = 1'b1;
               pc_we_o = 1'b1;
               state_d = S_DECODE;
            end else if (expired) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end else begin
               wait_d = wait_inc;
            end
         end
         S_DECODE: begin
            op_d = opcode_i;
            if (is_legal(opcode_i)) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_TRAP;
               cause_d = 2'b01;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_R: begin
                  ALUOp_o = 3'b010;
                  state_d = S_WB;
               end
               OP_I: begin
                  ALUOp_o  = 3'b011;
                  alusrc_o = 1'b1;
                  state_d  = S_WB;
               end
               OP_L, OP_S: begin
                  alusrc_o = 1'b1;
                  state_d  = S_MEM;
               end
               OP_B: begin
                  ALUOp_o  = 3'b001;
                  branch_o = 1'b1;
                  pc_we_o  = zero_i;
                  state_d  = S_FETCH;
               end
               default: begin
                  branch_o = 1'b1;
                  pc_we_o  = 1'b1;
                  state_d  = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            alusrc_o   = 1'b1;
            memread_o  = (op_q == OP_L);
            memwrite_o = (op_q == OP_S);
            if (dmem_ready_i) begin
               state_d = (op_q == OP_L) ? S_WB : S_FETCH;
            end else if (expired) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end else begin
               wait_d = wait_inc;
            end
         end
         S_WB: begin
            regwrite_o = 1'b1;
            memtoreg_o = (op_q == OP_L);
            state_d    = S_FETCH;
         end
         S_TRAP: trap_o = 1'b1;
         default: state_d = S_START;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_START;
         op_q    <= 7'd0;
         wait_q  <= 8'd0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wait_q  <= wait_d;
         cause_q <= cause_d;
      end
   end

   assign state_o      = state_q;
   assign trap_cause_o = cause_q;

`ifdef MCTRL_PERF_CNT_EN
   logic [31:0] instret_q;
   logic        retire;

   // One instruction retires on every return to FETCH from EXEC, MEM or WB.
   assign retire = (state_d == S_FETCH) &&
                   ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         instret_q <= 32'd0;
      end else if (retire) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle traces built from the
// instruction-level rules, queued and compared cycle by cycle against the DUT outputs.
module tb_multicycle_ctrl;

   localparam int unsigned TO = 4;

   localparam logic [2:0] ST_START = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                          ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;
   localparam logic [6:0] OP_I = 7'b0010011, OP_R = 7'b0110011, OP_S = 7'b0100011,
                          OP_L = 7'b0000011, OP_B = 7'b1100011, OP_J = 7'b1100111;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [6:0] opcode_i = 7'd0;
   logic       zero_i = 1'b0;
   logic       imem_ready_i = 1'b0;
   logic       dmem_ready_i = 1'b0;
   logic       imem_req_o, ir_we_o, pc_we_o, branch_o, regwrite_o, alusrc_o;
   logic       memtoreg_o, memread_o, memwrite_o, trap_o;
   logic [2:0] ALUOp_o, state_o;
   logic [1:0] trap_cause_o;
`ifdef MCTRL_PERF_CNT_EN
   logic [31:0] instret_o;
`endif

   multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .zero_i(zero_i),
      .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
      .imem_req_o(imem_req_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .branch_o(branch_o),
      .regwrite_o(regwrite_o), .alusrc_o(alusrc_o), .memtoreg_o(memtoreg_o),
      .memread_o(memread_o), .memwrite_o(memwrite_o), .ALUOp_o(ALUOp_o),
      .trap_o(trap_o), .trap_cause_o(trap_cause_o), .state_o(state_o)
`ifdef MCTRL_PERF_CNT_EN
      , .instret_o(instret_o)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- scoreboard state ----------------
   typedef struct {
      string       tag;
      logic        rst;
      logic        ir;
      logic        dr;
      logic [6:0]  op;
      logic        z;
      logic        chk;
      logic [31:0] exp_ir;
   } stim_t;

   stim_t       stim_q[$];
   logic [17:0] exp_q[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] ir_model = 32'd0;
   bit          trapped = 0;
   logic [1:0]  trap_cause = 2'b00;
   logic [6:0]  legal_ops[6] = '{OP_I, OP_R, OP_S, OP_L, OP_B, OP_J};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1;
      return 0;
   endfunction

   // strobes = {imem_req, ir_we, pc_we, branch, regwrite, alusrc, memtoreg, memread, memwrite}
   function automatic logic [17:0] mk(input logic [2:0] st, input logic [8:0] strb,
                                      input logic [2:0] aop, input logic trp, input logic [1:0] cs);
      return {st, strb, aop, trp, cs};
   endfunction

   // Negative input arguments mean "don't care": drive a random value.
   task automatic push(input string tag, input logic rst, input int ir, input int dr,
                       input int op, input int z, input logic chk, input logic [17:0] e);
      stim_t s;
      s.tag    = tag;
      s.rst    = rst;
      s.ir     = (ir < 0) ? 1'($urandom_range(0, 1)) : 1'(ir);
      s.dr     = (dr < 0) ? 1'($urandom_range(0, 1)) : 1'(dr);
      s.op     = (op < 0) ? 7'($urandom_range(0, 127)) : 7'(op);
      s.z      = (z < 0) ? 1'($urandom_range(0, 1)) : 1'(z);
      s.chk    = chk;
      s.exp_ir = ir_model;
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic push_start();
      trapped    = 0;
      trap_cause = 2'b00;
      ir_model   = 32'd0;
      push("start", 1'b1, -1, -1, -1, -1, 1'b1, mk(ST_START, 9'b0, 3'b000, 1'b0, 2'b00));
   endtask

   task automatic do_reset();
      push("rst", 1'b0, -1, -1, -1, -1, 1'b0, 18'd0);
      push_start();
   endtask

   // Assert reset during the last queued cycle (its outputs are still checked).
   task automatic reset_last();
      stim_t s;
      s = stim_q.pop_back();
      s.rst = 1'b0;
      stim_q.push_back(s);
      push_start();
   endtask

   task automatic trap_hold(input int n);
      for (int i = 0; i < n; i++)
         push("trap", 1'b1, -1, -1, -1, -1, 1'b1, mk(ST_TRAP, 9'b0, 3'b000, 1'b1, trap_cause));
   endtask

   // One instruction starting in FETCH: wi/wd are the number of not-ready cycles before ready.
   task automatic plan(input logic [6:0] op, input logic z, input int wi, input int wd);
      logic [8:0] mem_strb;
      for (int k = 0; k < 300; k++) begin
         if (k == wi) begin
            push("fetch", 1'b1, 1, -1, -1, -1, 1'b1, mk(ST_FETCH, 9'b111000000, 3'b000, 1'b0, 2'b00));
            break;
         end
         push("fetch_wait", 1'b1, 0, -1, -1, -1, 1'b1, mk(ST_FETCH, 9'b100000000, 3'b000, 1'b0, 2'b00));
         if (TO != 0 && k == int'(TO) - 1) begin
            trapped = 1; trap_cause = 2'b10;
            return;
         end
      end
      push("decode", 1'b1, -1, -1, int'(op), -1, 1'b1, mk(ST_DECODE, 9'b0, 3'b000, 1'b0, 2'b00));
      if (!is_legal(op)) begin
         trapped = 1; trap_cause = 2'b01;
         return;
      end
      case (op)
         OP_R: push("exec_r", 1'b1, -1, -1, -1, -1, 1'b1, mk(ST_EXEC, 9'b000000000, 3'b010, 1'b0, 2'b00));
         OP_I: push("exec_i", 1'b1, -1, -1, -1, -1, 1'b1, mk(ST_EXEC, 9'b000001000, 3'b011, 1'b0, 2'b00));
         OP_L, OP_S: push("exec_ls", 1'b1, -1, -1, -1, -1, 1'b1, mk(ST_EXEC, 9'b000001000, 3'b000, 1'b0, 2'b00));
         OP_B: begin
            push("exec_b", 1'b1, -1, -1, -1, int'(z), 1'b1, mk(ST_EXEC, {2'b00, z, 6'b100000}, 3'b001, 1'b0, 2'b00));
            ir_model++;
            return;
         end
         default: begin
            push("exec_j", 1'b1, -1, -1, -1, -1, 1'b1, mk(ST_EXEC, 9'b001100000, 3'b000, 1'b0, 2'b00));
            ir_model++;
            return;
         end
      endcase
      if (op == OP_L || op == OP_S) begin
         mem_strb = (op == OP_L) ? 9'b000001010 : 9'b000001001;
         for (int k = 0; k < 300; k++) begin
            if (k == wd) begin
               push("mem", 1'b1, -1, 1, -1, -1, 1'b1, mk(ST_MEM, mem_strb, 3'b000, 1'b0, 2'b00));
               break;
            end
            push("mem_wait", 1'b1, -1, 0, -1, -1, 1'b1, mk(ST_MEM, mem_strb, 3'b000, 1'b0, 2'b00));
            if (TO != 0 && k == int'(TO) - 1) begin
               trapped = 1; trap_cause = 2'b10;
               return;
            end
         end
         if (op == OP_S) begin
            ir_model++;
            return;
         end
      end
      push("wb", 1'b1, -1, -1, -1, -1, 1'b1,
           mk(ST_WB, (op == OP_L) ? 9'b000010100 : 9'b000010000, 3'b000, 1'b0, 2'b00));
      ir_model++;
   endtask

   // Drive one queued cycle per falling edge, then compare outputs shortly after.
   task automatic flush();
      stim_t       s;
      logic [17:0] e;
      logic [17:0] act;
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         @(negedge clk_i);
         rst_ni       = s.rst;
         imem_ready_i = s.ir;
         dmem_ready_i = s.dr;
         opcode_i     = s.op;
         zero_i       = s.z;
         #1;
         act = {state_o, imem_req_o, ir_we_o, pc_we_o, branch_o, regwrite_o, alusrc_o,
                memtoreg_o, memread_o, memwrite_o, ALUOp_o, trap_o, trap_cause_o};
         if (s.chk) begin
            check(s.tag, 32'(act), 32'(e));
`ifdef MCTRL_PERF_CNT_EN
            check({s.tag, "_instret"}, instret_o, s.exp_ir);
`endif
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [6:0] op;
      int         wi, wd;

      do_reset();
      plan(OP_R, 1'b0, 0, 0);                 // 000,001,010,011,101 then FETCH
      plan(OP_L, 1'b0, 0, 3);                 // memread held 4 cycles
      plan(OP_B, 1'b1, 0, 0);
      plan(OP_B, 1'b0, 0, 0);
      plan(OP_J, 1'b0, 1, 0);
      plan(7'b1111111, 1'b0, 0, 0);           // illegal opcode
      trap_hold(20);
      do_reset();
      plan(OP_I, 1'b0, int'(TO), 0);          // fetch timeout
      trap_hold(5);
      do_reset();
      plan(OP_I, 1'b0, int'(TO) - 1, 0);      // ready in expiry cycle wins
      plan(OP_S, 1'b0, 0, int'(TO));          // mem timeout
      trap_hold(5);
      do_reset();
      plan(OP_S, 1'b0, 0, int'(TO) - 1);
      flush();

      plan(OP_L, 1'b0, 0, 3);                 // reset in first MEM cycle
      while (exp_q.size() > 4) begin
         void'(stim_q.pop_back());
         void'(exp_q.pop_back());
      end
      reset_last();
      plan(OP_R, 1'b0, 0, 0);
      flush();

      do_reset();
      plan(OP_I, 1'b0, 0, 0);
      plan(OP_S, 1'b0, 0, 0);
      plan(OP_B, 1'b1, 0, 0);
      plan(OP_R, 1'b0, 0, 0);
      flush();
`ifdef MCTRL_PERF_CNT_EN
      @(posedge clk_i);
      #1;
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      ir_model = 32'hFFFF_FFFF;
      plan(OP_R, 1'b0, 0, 0);
      plan(OP_I, 1'b0, 0, 0);
      flush();
`endif

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            op = 7'($urandom_range(0, 127));
            for (int t = 0; t < 100 && is_legal(op); t++) op = 7'($urandom_range(0, 127));
         end else begin
            op = legal_ops[$urandom_range(0, 5)];
         end
         wi = ($urandom_range(0, 11) == 0) ? int'(TO) + int'($urandom_range(0, 2)) : int'($urandom_range(0, TO - 1));
         wd = ($urandom_range(0, 11) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
         plan(op, 1'($urandom_range(0, 1)), wi, wd);
         if (trapped) begin
            trap_hold(int'($urandom_range(1, 6)));
            do_reset();
         end
         flush();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
